uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, frame
// configuration encodings and the frame parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
        case (len)
            LEN_5:   last_bit_idx = 3'd4;
            LEN_6:   last_bit_idx = 3'd5;
            LEN_7:   last_bit_idx = 3'd6;
            LEN_8:   last_bit_idx = 3'd7;
            default: last_bit_idx = 3'd7;
        endcase
    endfunction

    function automatic logic parity_enabled(input logic [1:0] ptype);
        parity_enabled = (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

    // Only the bits that are actually transmitted take part in the parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] len,
                                        input logic [1:0] ptype);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - len);
        x    = ^(data & mask);
        case (ptype)
            PAR_ODD:  parity_bit = ~x;
            PAR_EVEN: parity_bit = x;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered level/full/empty flags and an overflow pulse
// for writes that are dropped because the buffer is full.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             pop_s;
    logic             push_s;

    // A pop frees a slot in the same cycle, so a write to a full FIFO is kept then.
    assign pop_s  = rd_en && !empty_r;
    assign push_s = wr_en && (!full_r || pop_s);

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;
    assign overflow = overflow_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Pointers, occupancy flags and the overflow pulse.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r    <= level_nxt_s;
            full_r     <= (level_nxt_s == LW'(DEPTH));
            empty_r    <= (level_nxt_s == LW'(0));
            overflow_r <= wr_en && full_r && !pop_s;
        end
    end

    // Storage array; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of payloads feeding a serialiser whose frame
// format and bit rate are latched from the configuration inputs at each pop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_MAX   = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_MAX-1:0]           wr_data,
    input  logic [1:0]                    data_length,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_bits,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          data_out,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    logic [DATA_MAX-1:0] rd_data_s;
    logic [7:0]          frame_byte_s;
    logic                empty_s;
    logic                rd_en_s;
    logic                bit_end_s;
    logic                frame_end_s;

    tx_state_e           state_r;
    logic [DIV_W-1:0]    baud_cnt_r;
    logic [DIV_W-1:0]    div_r;
    logic [2:0]          bit_cnt_r;
    logic [2:0]          last_idx_r;
    logic [7:0]          shift_r;
    logic                par_en_r;
    logic                par_r;
    logic                stop2_r;
    logic                data_out_r;
    logic                tx_active_r;
    logic                tx_done_r;

    uart_fifo #(
        .WIDTH (DATA_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en_s),
        .rd_data  (rd_data_s),
        .full     (fifo_full),
        .empty    (empty_s),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign frame_byte_s = 8'(rd_data_s);
    assign bit_end_s    = (baud_cnt_r == div_r);
    assign frame_end_s  = (state_r == ST_STOP) && bit_end_s && (!stop2_r || (bit_cnt_r == 3'd1));
    // Pop from IDLE, or at the very end of a frame so the next one follows with no gap.
    assign rd_en_s      = !empty_s && ((state_r == ST_IDLE) || frame_end_s);

    assign fifo_empty = empty_s;
    assign data_out   = data_out_r;
    assign tx_active  = tx_active_r;
    assign tx_done    = tx_done_r;

    // Transmit FSM with baud and bit counters and registered line outputs.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= '0;
            div_r       <= '0;
            bit_cnt_r   <= 3'd0;
            last_idx_r  <= 3'd0;
            shift_r     <= 8'd0;
            par_en_r    <= 1'b0;
            par_r       <= 1'b0;
            stop2_r     <= 1'b0;
            data_out_r  <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= frame_end_s;
            if (rd_en_s) begin
                state_r     <= ST_START;
                shift_r     <= frame_byte_s;
                last_idx_r  <= last_bit_idx(data_length);
                par_en_r    <= parity_enabled(parity_type);
                par_r       <= parity_bit(frame_byte_s, data_length, parity_type);
                stop2_r     <= stop_bits;
                div_r       <= baud_div;
                baud_cnt_r  <= '0;
                bit_cnt_r   <= 3'd0;
                data_out_r  <= 1'b0;
                tx_active_r <= 1'b1;
            end else if (state_r != ST_IDLE && !bit_end_s) begin
                baud_cnt_r <= baud_cnt_r + DIV_W'(1);
            end else begin
                baud_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        data_out_r  <= 1'b1;
                        tx_active_r <= 1'b0;
                    end
                    ST_START: begin
                        state_r    <= ST_DATA;
                        data_out_r <= shift_r[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt_r == last_idx_r) begin
                            bit_cnt_r  <= 3'd0;
                            state_r    <= par_en_r ? ST_PARITY : ST_STOP;
                            data_out_r <= par_en_r ? par_r : 1'b1;
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            shift_r    <= shift_r >> 1;
                            data_out_r <= shift_r[1];
                        end
                    end
                    ST_PARITY: begin
                        state_r    <= ST_STOP;
                        data_out_r <= 1'b1;
                    end
                    ST_STOP: begin
                        if (frame_end_s) begin
                            state_r     <= ST_IDLE;
                            bit_cnt_r   <= 3'd0;
                            tx_active_r <= 1'b0;
                        end else begin
                            bit_cnt_r <= 3'd1;
                        end
                        data_out_r <= 1'b1;
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        data_out_r  <= 1'b1;
                        tx_active_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a frame-level model
// that expands each queued payload into its expected serial bit sequence.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;

    typedef struct {
        logic [7:0] data;
        logic [1:0] len;
        logic [1:0] ptype;
        logic       stop2;
        int         div;
    } frame_t;

    logic        clock = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [1:0]  data_length;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic [15:0] baud_div;
    logic        data_out;
    logic        tx_active;
    logic        tx_done;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    uart_tx_fifo dut (
        .clock       (clock),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .data_length (data_length),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .baud_div    (baud_div),
        .data_out    (data_out),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_len(input frame_t f);
        int n;
        int pe;
        n  = 5 + int'(f.len);
        pe = (f.ptype == 2'd1 || f.ptype == 2'd2) ? 1 : 0;
        return 1 + n + pe + 1 + int'(f.stop2);
    endfunction

    function automatic logic model_bit(input frame_t f, input int idx);
        int n;
        int ones;
        logic pe;
        n    = 5 + int'(f.len);
        pe   = (f.ptype == 2'd1 || f.ptype == 2'd2);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(f.data[i]);
        if (idx == 0) return 1'b0;
        if (idx <= n) return f.data[idx-1];
        if (pe && idx == n + 1) begin
            if (f.ptype == 2'd1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
            return (ones % 2 == 1) ? 1'b1 : 1'b0;
        end
        return 1'b1;
    endfunction

    // Entered on the first cycle of the start bit; leaves on the cycle after the last stop bit.
    task automatic expect_frame(input frame_t f);
        int total;
        total = model_len(f);
        for (int idx = 0; idx < total; idx++) begin
            for (int c = 0; c <= f.div; c++) begin
                if (!(idx == 0 && c == 0)) begin
                    @(negedge clock);
                    check_val("tx_done_early", tx_done, 0);
                end
                check_val($sformatf("bit%0d", idx), data_out, model_bit(f, idx));
                if (c == 0) check_val("tx_active", tx_active, 1);
            end
        end
        @(negedge clock);
        check_val("tx_done", tx_done, 1);
        if (tx_done === 1'b1) done_cnt++;
    endtask

    task automatic apply_cfg(input frame_t f);
        data_length = f.len;
        parity_type = f.ptype;
        stop_bits   = f.stop2;
        baud_div    = 16'(f.div);
    endtask

    // Single frame into an idle transmitter; config is scrambled once it has been latched.
    task automatic send_one(input frame_t f);
        @(negedge clock);
        apply_cfg(f);
        wr_data = f.data;
        wr_en   = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        check_val("lat_n1_line", data_out, 1);
        check_val("lat_n1_level", fifo_level, 1);
        @(negedge clock);
        check_val("lat_n2_start", data_out, 0);
        check_val("lat_n2_level", fifo_level, 0);
        data_length = 2'($urandom);
        parity_type = 2'($urandom);
        stop_bits   = 1'($urandom);
        baud_div    = 16'($urandom_range(0, 7));
        expect_frame(f);
        check_val("idle_line", data_out, 1);
        check_val("idle_active", tx_active, 0);
        check_val("idle_empty", fifo_empty, 1);
    endtask

    initial begin
        frame_t f;
        frame_t q[$];
        int base_done;
        int quiet;
        logic seen;

        rst = 1'b0; wr_en = 1'b0; wr_data = 8'd0;
        data_length = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; baud_div = 16'd4;
        repeat (3) @(negedge clock);
        check_val("rst_line", data_out, 1);
        check_val("rst_active", tx_active, 0);
        check_val("rst_done", tx_done, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_empty", fifo_empty, 1);
        check_val("rst_full", fifo_full, 0);
        check_val("rst_level", fifo_level, 0);
        rst = 1'b1;
        repeat (2) @(negedge clock);

        // Directed frames: 8N1 0xA5, 7E2 0x55, 5O1 0xFF, and single-clock bits with parity.
        f = '{data: 8'hA5, len: 2'b11, ptype: 2'b00, stop2: 1'b0, div: 4};
        send_one(f);
        f = '{data: 8'h55, len: 2'b10, ptype: 2'b10, stop2: 1'b1, div: 2};
        check_val("len_7e2", model_len(f), 11);
        send_one(f);
        f = '{data: 8'hFF, len: 2'b00, ptype: 2'b01, stop2: 1'b0, div: 1};
        send_one(f);
        f = '{data: 8'h3C, len: 2'b11, ptype: 2'b01, stop2: 1'b0, div: 0};
        send_one(f);

        for (int k = 0; k < 12; k++) begin
            f.data  = 8'($urandom);
            f.len   = 2'($urandom);
            f.ptype = 2'($urandom);
            f.stop2 = 1'($urandom);
            f.div   = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send_one(f);
        end

        // Fill while busy: eight accepted, the ninth dropped with an overflow pulse.
        f = '{data: 8'h81, len: 2'b11, ptype: 2'b00, stop2: 1'b0, div: 20};
        @(negedge clock);
        apply_cfg(f);
        wr_data = f.data;
        wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        @(negedge clock);
        check_val("ovf_busy_start", data_out, 0);
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            if (i < DEPTH) begin
                f.data = wr_data;
                q.push_back(f);
            end
            @(negedge clock);
            check_val($sformatf("ovf_pulse%0d", i), overflow, (i == 8) ? 1 : 0);
            check_val($sformatf("ovf_level%0d", i), fifo_level, (i < DEPTH) ? i + 1 : DEPTH);
            check_val($sformatf("ovf_full%0d", i), fifo_full, (i >= DEPTH - 1) ? 1 : 0);
        end
        wr_en = 1'b0;
        @(negedge clock);
        check_val("ovf_clear", overflow, 0);

        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clock);
            if (tx_done === 1'b1) seen = 1'b1;
        end
        check_val("drain_wait", seen, 1);
        check_val("drain_level", fifo_level, DEPTH - 1);
        base_done = done_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            check_val($sformatf("no_gap%0d", k), data_out, 0);
            expect_frame(q[k]);
        end
        check_val("drain_dones", done_cnt - base_done, DEPTH);
        check_val("drain_line", data_out, 1);
        check_val("drain_active", tx_active, 0);
        check_val("drain_empty", fifo_empty, 1);

        // Reset in the middle of DATA with another entry still queued.
        f = '{data: 8'h96, len: 2'b11, ptype: 2'b10, stop2: 1'b0, div: 3};
        @(negedge clock);
        apply_cfg(f);
        wr_data = f.data;
        wr_en = 1'b1;
        @(negedge clock);
        wr_data = 8'h3C;
        @(negedge clock);
        wr_en = 1'b0;
        repeat ((f.div + 1) * 3) @(negedge clock);
        check_val("pre_rst_active", tx_active, 1);
        check_val("pre_rst_level", fifo_level, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_line", data_out, 1);
        check_val("mid_rst_level", fifo_level, 0);
        check_val("mid_rst_empty", fifo_empty, 1);
        check_val("mid_rst_active", tx_active, 0);
        check_val("mid_rst_done", tx_done, 0);
        @(negedge clock);
        rst = 1'b1;
        quiet = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (data_out !== 1'b1 || tx_active !== 1'b0 || fifo_level !== 4'd0) quiet++;
        end
        check_val("post_rst_quiet", quiet, 0);
        f = '{data: 8'h4E, len: 2'b01, ptype: 2'b10, stop2: 1'b1, div: 1};
        send_one(f);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
